// File: rtl/fifo_pkg.sv
// Shared FIFO-side types: read-drain FSM state and default widths.
package fifo_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus valid/ready output stream seen by the burst reader.
interface fifo_burst_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned N = N_DEF
);

    logic         fifo_ren;
    logic         fifo_empty;
    logic [N-1:0] fifo_rdata;

    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
    logic         m_last;

    // Reader side: drives the FIFO read enable and the output stream.
    modport master (
        output fifo_ren,
        input  fifo_empty,
        input  fifo_rdata,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    // Environment side: the FIFO plus the downstream consumer.
    modport slave (
        input  fifo_ren,
        output fifo_empty,
        output fifo_rdata,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry in-order queue with a last flag per word; head entry drives the stream.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned W = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [1:0]   occ_q, occ_d;
    logic [W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic         last0_q, last0_d, last1_q, last1_d;
    logic         do_pop_c, do_push_c;

    // Pop shifts entry 1 forward; push then lands in the first free slot.
    always_comb begin
        occ_d     = occ_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        last0_d   = last0_q;
        last1_d   = last1_q;
        do_pop_c  = pop && (occ_q != 2'd0);
        do_push_c = push && ((occ_q != 2'd2) || do_pop_c);

        if (do_pop_c) begin
            data0_d = data1_q;
            last0_d = last1_q;
            occ_d   = occ_q - 2'd1;
        end

        if (do_push_c) begin
            if (occ_d == 2'd0) begin
                data0_d = push_data;
                last0_d = push_last;
            end else begin
                data1_d = push_data;
                last1_d = push_last;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

    assign occ        = occ_q;
    assign head_valid = (occ_q != 2'd0);
    assign head_data  = data0_q;
    assign head_last  = last0_q && (occ_q != 2'd0);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains exactly len words from a synchronous FIFO onto a valid/ready stream,
// hiding the FIFO read latency behind a two-entry skid buffer.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    fifo_burst_reader_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);
    localparam logic [1:0] S_DONE  = 2'(DONE);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_last_q, rd_last_d;

    logic [1:0]       occ;
    logic             head_valid;
    logic             head_last;
    logic [N-1:0]     head_data;
    logic             pop_c;
    logic             ren_c;

    assign pop_c = head_valid && bus.m_ready;

    // Reads in flight after this cycle (buffered + pending - popped) must stay below 2.
    assign ren_c = (state_q == S_RUN) && (issue_cnt_q != '0) && !bus.fifo_empty &&
                   ((3'(occ) + 3'(rd_pend_q)) < (3'd2 + 3'(pop_c)));

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        rd_pend_d   = ren_c;
        rd_last_d   = ren_c && (issue_cnt_q == LEN_W'(1));

        if (ren_c) begin
            issue_cnt_d = issue_cnt_q - LEN_W'(1);
        end
        if (pop_c && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        issue_cnt_d = len;
                        out_cnt_d   = len;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (ren_c && (issue_cnt_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop_c && (out_cnt_q == LEN_W'(1))) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // FIFO data arrives the cycle after a read and is captured on that cycle's edge.
    skid_buf2 #(
        .W (N)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (rd_pend_q),
        .push_data  (bus.fifo_rdata),
        .push_last  (rd_last_q),
        .pop        (pop_c),
        .occ        (occ),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_last  (head_last)
    );

    assign bus.fifo_ren = ren_c;
    assign bus.m_valid  = head_valid;
    assign bus.m_data   = head_data;
    assign bus.m_last   = head_last;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + randomized bench: behavioural FIFO, expected-word queue and stream monitors.
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned LEN_W = 8;

    typedef struct {
        logic [N-1:0] d;
        logic         last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;

    fifo_burst_reader_if #(.N(N)) bus ();

    fifo_burst_reader #(.N(N), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural FIFO: mem is pre-filled, wr_ptr marks how much is "written".
    logic [N-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_ren && !bus.fifo_empty) begin
            bus.fifo_rdata <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    exp_t exp_q[$];
    int   next_base = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;
    int   rdy_ph = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_burst(input int l, input bit accepted);
        start = 1'b1;
        len   = LEN_W'(l);
        if (accepted) begin
            for (int i = 0; i < l; i++) begin
                exp_q.push_back('{d: mem[next_base + i], last: (i == l - 1)});
            end
            next_base += l;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", 64'(done_cnt > d0), 64'(1));
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       begin bus.m_ready = (rdy_ph % 3 == 0); rdy_ph++; end
            2:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = 1'b0;
        endcase
    end

    // Stream monitor: order, last flag, stall stability, in-flight bound, done pulse.
    logic         prev_stall = 1'b0;
    logic         prev_done  = 1'b0;
    logic [N-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;
    int           inflight   = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            inflight   = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            automatic bit rd = bus.fifo_ren && !bus.fifo_empty;
            automatic bit hs = bus.m_valid && bus.m_ready;
            if (bus.fifo_empty) check("ren_while_empty", 64'(bus.fifo_ren), 64'(0));
            if (prev_stall) begin
                check("stall_valid", 64'(bus.m_valid), 64'(1));
                check("stall_data", 64'(bus.m_data), 64'(prev_data));
                check("stall_last", 64'(bus.m_last), 64'(prev_last));
            end
            if (hs) begin
                check("word_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    automatic exp_t e = exp_q.pop_front();
                    check("m_data", 64'(bus.m_data), 64'(e.d));
                    check("m_last", 64'(bus.m_last), 64'(e.last));
                end
                hs_cnt++;
            end
            inflight = inflight + int'(rd) - int'(hs);
            check("inflight_le2", 64'(inflight <= 2), 64'(1));
            if (done) begin
                done_cnt++;
                check("done_all_delivered", 64'(exp_q.size() == 0), 64'(1));
            end
            if (prev_done) check("done_one_cycle", 64'(done), 64'(0));
            prev_done  = done;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    initial begin
        int h0;
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = N'(32'hA0 + i);
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ren", 64'(bus.fifo_ren), 64'(0));
        check("rst_valid", 64'(bus.m_valid), 64'(0));
        check("rst_last", 64'(bus.m_last), 64'(0));
        check("rst_data", 64'(bus.m_data), 64'(0));
        rst = 1'b0;
        step();

        // Basic burst: four words, full throughput, exact cycle timing.
        wr_ptr = 4;
        start_burst(4, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            check("t1_ren", 64'(bus.fifo_ren), 64'(c >= 1 && c <= 4));
            check("t1_valid", 64'(bus.m_valid), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                check("t1_data", 64'(bus.m_data), 64'(32'hA0 + c - 3));
                check("t1_last", 64'(bus.m_last), 64'(c == 6));
            end
            check("t1_done", 64'(done), 64'(c == 7));
            check("t1_busy", 64'(busy), 64'(c <= 7));
            step();
        end

        // Backpressure: ready 1,0,0 repeating over six words.
        rdy_mode = 1;
        wr_ptr  += 6;
        h0 = hs_cnt;
        start_burst(6, 1'b1);
        wait_done(200);
        check("t2_words", 64'(hs_cnt - h0), 64'(6));
        check("t2_idle", 64'(busy), 64'(0));

        // FIFO underflow: two words present, three more arrive after a stall.
        rdy_mode = 2;
        wr_ptr  += 2;
        h0 = hs_cnt;
        start_burst(5, 1'b1);
        repeat (10) step();
        check("t3_stall_busy", 64'(busy), 64'(1));
        check("t3_fifo_drained", 64'(rd_ptr == wr_ptr), 64'(1));
        wr_ptr += 3;
        wait_done(200);
        check("t3_words", 64'(hs_cnt - h0), 64'(5));

        // Zero length: a done pulse, no reads, no output.
        rdy_mode = 0;
        step();
        d0 = done_cnt;
        h0 = hs_cnt;
        start_burst(0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            check("t4_no_ren", 64'(bus.fifo_ren), 64'(0));
            check("t4_no_valid", 64'(bus.m_valid), 64'(0));
            step();
        end
        check("t4_one_done", 64'(done_cnt - d0), 64'(1));
        check("t4_no_words", 64'(hs_cnt - h0), 64'(0));

        // A start while busy is ignored: exactly four words leave, three stay in the FIFO.
        wr_ptr += 7;
        h0 = hs_cnt;
        start_burst(4, 1'b1);
        step();
        start_burst(3, 1'b0);
        wait_done(100);
        check("t4_ignored_words", 64'(hs_cnt - h0), 64'(4));
        check("t4_fifo_left", 64'(wr_ptr - rd_ptr), 64'(3));

        // Reset with two reads in flight; the FIFO is not rewound.
        rdy_mode = 3;
        wr_ptr  += 5;
        start_burst(6, 1'b1);
        step();
        step();
        check("t5_busy_pre", 64'(busy), 64'(1));
        check("t5_valid_pre", 64'(bus.m_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_done", 64'(done), 64'(0));
        check("t5_rst_ren", 64'(bus.fifo_ren), 64'(0));
        check("t5_rst_valid", 64'(bus.m_valid), 64'(0));
        check("t5_rst_last", 64'(bus.m_last), 64'(0));
        check("t5_rst_data", 64'(bus.m_data), 64'(0));
        exp_q.delete();
        next_base = rd_ptr;
        step();
        step();
        rst      = 1'b0;
        rdy_mode = 0;
        step();
        h0 = hs_cnt;
        start_burst(2, 1'b1);
        wait_done(100);
        check("t5_words", 64'(hs_cnt - h0), 64'(2));
        check("t5_idle", 64'(busy), 64'(0));

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
